// File: rtl/msx_mapper_pkg.sv
// msx_mapper_pkg: shared types and constants for the MSX mapper / PSRAM bridge.
// Holds the bridge FSM state encoding, segment register reset values and the
// MSX idle data-bus value.
package msx_mapper_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_R   = 3'd1,
    REQ_W   = 3'd2,
    GUARD   = 3'd3,
    WAIT    = 3'd4,
    HOLD    = 3'd5,
    IO_HOLD = 3'd6
  } mapper_state_e;

  // Power-on mapping: page 0 -> segment 3, page 1 -> 2, page 2 -> 1, page 3 -> 0.
  localparam logic [7:0] SEG_RST_0 = 8'd3;
  localparam logic [7:0] SEG_RST_1 = 8'd2;
  localparam logic [7:0] SEG_RST_2 = 8'd1;
  localparam logic [7:0] SEG_RST_3 = 8'd0;

  // Value an undriven MSX data bus reads as.
  localparam logic [7:0] MSX_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/msx_mapper_bridge_regfile.sv
// mapper_regfile: four SEG_BITS-wide segment registers with a synchronous
// write port and a combinational read port. The read port doubles as the
// page-to-segment select (rd_sel = addr[15:14]) or the I/O readback select.
module mapper_regfile
  import msx_mapper_pkg::*;
#(
  parameter int SEG_BITS = 8
) (
  input  logic                clk_72m,
  input  logic                bus_reset_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [SEG_BITS-1:0] wr_data,
  input  logic [1:0]          rd_sel,
  output logic [SEG_BITS-1:0] rd_data
);

  logic [SEG_BITS-1:0] seg_q [4];

  // Segment registers: reset to the power-on mapping, written by mapper OUTs.
  always_ff @(posedge clk_72m) begin
    if (!bus_reset_n) begin
      seg_q[0] <= SEG_RST_0[SEG_BITS-1:0];
      seg_q[1] <= SEG_RST_1[SEG_BITS-1:0];
      seg_q[2] <= SEG_RST_2[SEG_BITS-1:0];
      seg_q[3] <= SEG_RST_3[SEG_BITS-1:0];
    end else if (wr_en) begin
      seg_q[wr_sel] <= wr_data;
    end
  end

  // Combinational read / page select.
  always_comb begin
    rd_data = seg_q[rd_sel];
  end

endmodule

// File: rtl/msx_mapper_bridge.sv
// msx_mapper_bridge: MSX memory mapper plus single-shot PSRAM byte bridge.
// Optional build macro: MSX_MAPPER_READBACK_EN enables I/O readback of the
// segment registers (upper unused bits read as 1).
//
// PSRAM handshake: psram_read / psram_write are one-cycle request pulses with
// psram_addr / psram_din stable from the pulse until the next request. The
// controller may raise psram_busy up to one cycle late (hence GUARD); a
// request is complete on the first WAIT cycle that sees psram_busy=0.
module msx_mapper_bridge
  import msx_mapper_pkg::*;
#(
  parameter int         SEG_BITS     = 8,
  parameter int         PSRAM_ADDR_W = 22,
  parameter logic [7:0] IO_BASE      = 8'hFC,
  parameter int         TIMEOUT_CYC  = 255
) (
  input  logic                    clk_72m,
  input  logic                    bus_reset_n,
  input  logic [15:0]             bus_addr,
  input  logic [7:0]              bus_din,
  input  logic                    bus_mreq_n,
  input  logic                    bus_iorq_n,
  input  logic                    bus_rd_n,
  input  logic                    bus_wr_n,
  input  logic                    bus_sltsl_n,
  input  logic                    bus_rfsh_n,
  output logic [7:0]              bus_dout,
  output logic                    bus_data_reverse,
  output logic                    psram_read,
  output logic                    psram_write,
  output logic [PSRAM_ADDR_W-1:0] psram_addr,
  output logic [15:0]             psram_din,
  input  logic [15:0]             psram_dout,
  input  logic                    psram_busy,
  output logic                    timeout_err,
  output logic                    fsm_busy
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  mapper_state_e state_q, state_d;

  logic             mem_rd_q, mem_rd_p, mem_wr_q, mem_wr_p, io_wr_q, io_wr_p;
  logic             mem_rd_rise, mem_wr_rise, io_wr_rise, io_hit;
  logic             op_read_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       seg_sel;
  logic [SEG_BITS-1:0] seg_val;
  logic [PSRAM_ADDR_W-1:0] addr_next;

  assign io_hit      = (bus_addr[7:2] == IO_BASE[7:2]);
  assign mem_rd_rise = mem_rd_q & ~mem_rd_p;
  assign mem_wr_rise = mem_wr_q & ~mem_wr_p;
  assign io_wr_rise  = io_wr_q & ~io_wr_p;

  // Register qualified strobes once, and keep the previous sample for edges.
  always_ff @(posedge clk_72m) begin
    if (!bus_reset_n) begin
      mem_rd_q <= 1'b0;
      mem_rd_p <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_wr_p <= 1'b0;
      io_wr_q  <= 1'b0;
      io_wr_p  <= 1'b0;
    end else begin
      mem_rd_q <= ~bus_mreq_n & ~bus_rd_n & ~bus_sltsl_n & bus_rfsh_n;
      mem_wr_q <= ~bus_mreq_n & ~bus_wr_n & ~bus_sltsl_n & bus_rfsh_n;
      io_wr_q  <= ~bus_iorq_n & ~bus_wr_n & io_hit;
      mem_rd_p <= mem_rd_q;
      mem_wr_p <= mem_wr_q;
      io_wr_p  <= io_wr_q;
    end
  end

`ifdef MSX_MAPPER_READBACK_EN
  logic       io_rd_q, io_rd_p, io_rd_rise;
  logic [7:0] readback;

  assign io_rd_rise = io_rd_q & ~io_rd_p;

  // Registered I/O read strobe and its edge history.
  always_ff @(posedge clk_72m) begin
    if (!bus_reset_n) begin
      io_rd_q <= 1'b0;
      io_rd_p <= 1'b0;
    end else begin
      io_rd_q <= ~bus_iorq_n & ~bus_rd_n & io_hit;
      io_rd_p <= io_rd_q;
    end
  end

  // Readback select wins only when no memory trigger claims the read port.
  always_comb begin
    readback               = 8'hFF;
    readback[SEG_BITS-1:0] = seg_val;
    seg_sel                = bus_addr[15:14];
    if (state_q == IO_HOLD ||
        (state_q == IDLE && !mem_wr_rise && !mem_rd_rise)) begin
      seg_sel = bus_addr[1:0];
    end
  end
`else
  // Read port only ever serves page-to-segment translation.
  always_comb begin
    seg_sel = bus_addr[15:14];
  end
`endif

  mapper_regfile #(.SEG_BITS(SEG_BITS)) u_regfile (
    .clk_72m     (clk_72m),
    .bus_reset_n (bus_reset_n),
    .wr_en       (io_wr_rise),
    .wr_sel      (bus_addr[1:0]),
    .wr_data     (bus_din[SEG_BITS-1:0]),
    .rd_sel      (seg_sel),
    .rd_data     (seg_val)
  );

  // PSRAM byte address: {zero pad, segment, page offset}.
  always_comb begin
    addr_next                     = '0;
    addr_next[13:0]               = bus_addr[13:0];
    addr_next[SEG_BITS+13:14]     = seg_val;
  end

  // FSM state register.
  always_ff @(posedge clk_72m) begin
    if (!bus_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_wr_rise)      state_d = REQ_W;
        else if (mem_rd_rise) state_d = REQ_R;
`ifdef MSX_MAPPER_READBACK_EN
        else if (io_rd_rise)  state_d = IO_HOLD;
`endif
      end
      REQ_R, REQ_W: state_d = GUARD;
      GUARD:        state_d = WAIT;
      WAIT: begin
        if (!psram_busy || cnt_q == CNT_W'(TIMEOUT_CYC)) state_d = HOLD;
      end
      HOLD: begin
        if (op_read_q ? !mem_rd_q : !mem_wr_q) state_d = IDLE;
      end
`ifdef MSX_MAPPER_READBACK_EN
      IO_HOLD: if (!io_rd_q) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latch, busy timeout counter, read data and error flag.
  always_ff @(posedge clk_72m) begin
    if (!bus_reset_n) begin
      psram_addr  <= '0;
      psram_din   <= '0;
      bus_dout    <= MSX_IDLE_DATA;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
      op_read_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && (state_d == REQ_R || state_d == REQ_W)) begin
        psram_addr <= addr_next;
        psram_din  <= {bus_din, bus_din};
        op_read_q  <= (state_d == REQ_R);
      end
      if (state_q == GUARD) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (!psram_busy) begin
          if (op_read_q) bus_dout <= psram_addr[0] ? psram_dout[15:8] : psram_dout[7:0];
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          timeout_err <= 1'b1;
          if (op_read_q) bus_dout <= MSX_IDLE_DATA;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
`ifdef MSX_MAPPER_READBACK_EN
      if (state_d == IO_HOLD) bus_dout <= readback;
`endif
    end
  end

  assign psram_read       = (state_q == REQ_R);
  assign psram_write      = (state_q == REQ_W);
  assign bus_data_reverse = (state_q == HOLD && op_read_q) || (state_q == IO_HOLD);
  assign fsm_busy         = (state_q != IDLE);

endmodule
